// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The sequencer drives the strobes; the datapath returns opcode and memory ready.
interface mc_controller_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic               mem_ready;
    logic               memreq;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               pcwrite;
    logic               branch;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         aluop;
    logic [1:0]         pcsrc;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, mem_ready,
        output memreq, iord, memwrite, irwrite, pcwrite, branch,
        output alusrca, alusrcb, aluop, pcsrc,
        output regdst, memtoreg, regwrite, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  memreq, iord, memwrite, irwrite, pcwrite, branch,
        input  alusrca, alusrcb, aluop, pcsrc,
        input  regdst, memtoreg, regwrite, illegal_op, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control sequencer: Moore FSM stepping fetch, decode,
// execute, memory and writeback, with ready-qualified memory wait states.
module mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    mc_controller_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t st;
    state_t st_nxt;
    logic   rdy;

    logic       memreq;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;

    assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st <= FETCH;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt     = FETCH;
        memreq     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;

        case (st)
            FETCH: begin
                memreq  = 1'b1;
                alusrcb = 2'b01;
                irwrite = rdy;
                pcwrite = rdy;
                st_nxt  = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                // ALUOut captures PC+4 + (signimm<<2) for a possible BEQ
                alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: st_nxt = MEMADR;
                    OP_RTYPE:     st_nxt = RTYPEEX;
                    OP_BEQ:       st_nxt = BEQEX;
                    OP_ADDI:      st_nxt = ADDIEX;
                    OP_J:         st_nxt = JEX;
                    default: begin
                        illegal_op = 1'b1;
                        st_nxt     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                st_nxt  = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
                st_nxt = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                st_nxt   = FETCH;
            end
            MEMWR: begin
                memreq   = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                st_nxt   = rdy ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                st_nxt  = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                st_nxt   = FETCH;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                st_nxt  = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                st_nxt  = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                st_nxt   = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                st_nxt  = FETCH;
            end
            default: st_nxt = FETCH;
        endcase
    end

    assign bus.memreq     = memreq;
    assign bus.iord       = iord;
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.pcwrite    = pcwrite;
    assign bus.branch     = branch;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.aluop      = aluop;
    assign bus.pcsrc      = pcsrc;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = STATE_W'(st);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for the multicycle sequencer: state walks, strobes,
// wait states, illegal opcode and asynchronous reset.
module tb_mc_controller;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    mc_controller_if #(.STATE_W(4)) bus ();

    mc_controller #(
        .MEM_HANDSHAKE(1'b1),
        .STATE_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic no_wr(input string tag);
        check({tag, " regwrite"}, 32'(bus.regwrite), 0);
        check({tag, " memwrite"}, 32'(bus.memwrite), 0);
        check({tag, " pcwrite"},  32'(bus.pcwrite),  0);
        check({tag, " irwrite"},  32'(bus.irwrite),  0);
        check({tag, " branch"},   32'(bus.branch),   0);
    endtask

    int lw_seq[6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        nchk          = 0;
        nerr          = 0;
        reset         = 1'b1;
        bus.op        = 6'b100011;
        bus.mem_ready = 1'b1;
        tick();
        check("rst state", 32'(bus.state), 0);
        check("rst irwrite", 32'(bus.irwrite), 1);
        check("rst pcwrite", 32'(bus.pcwrite), 1);
        check("rst memreq", 32'(bus.memreq), 1);
        check("rst alusrcb", 32'(bus.alusrcb), 1);
        check("rst regwrite", 32'(bus.regwrite), 0);
        reset = 1'b0;

        // LW, zero wait states
        for (int i = 1; i < 6; i++) begin
            tick();
            check("lw state", 32'(bus.state), 32'(lw_seq[i]));
            check("lw regwrite", 32'(bus.regwrite), 32'(lw_seq[i] == 4));
            check("lw memtoreg", 32'(bus.memtoreg), 32'(lw_seq[i] == 4));
            if (lw_seq[i] == 3)
                check("lw iord", 32'(bus.iord), 1);
            if (lw_seq[i] == 2)
                check("lw adr alusrcb", 32'(bus.alusrcb), 2);
        end

        // SW with two wait states in MEMWR
        bus.op = 6'b101011;
        tick();
        check("sw decode", 32'(bus.state), 1);
        check("sw decode alusrcb", 32'(bus.alusrcb), 3);
        tick();
        check("sw memadr", 32'(bus.state), 2);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("sw memwr", 32'(bus.state), 5);
            check("sw memwrite", 32'(bus.memwrite), 1);
            check("sw regwrite", 32'(bus.regwrite), 0);
            tick();
            if (i == 1)
                bus.mem_ready = 1'b1;
            #1;
        end
        check("sw back", 32'(bus.state), 0);

        // R-type then BEQ
        bus.op = 6'b000000;
        tick();
        tick();
        check("r ex", 32'(bus.state), 6);
        check("r aluop", 32'(bus.aluop), 2);
        check("r alusrcb", 32'(bus.alusrcb), 0);
        tick();
        check("r wb", 32'(bus.state), 7);
        check("r regdst", 32'(bus.regdst), 1);
        check("r regwrite", 32'(bus.regwrite), 1);
        tick();
        check("r back", 32'(bus.state), 0);
        bus.op = 6'b000100;
        tick();
        tick();
        check("beq ex", 32'(bus.state), 8);
        check("beq branch", 32'(bus.branch), 1);
        check("beq pcsrc", 32'(bus.pcsrc), 1);
        check("beq aluop", 32'(bus.aluop), 1);
        tick();
        check("beq back", 32'(bus.state), 0);

        // J then ADDI
        bus.op = 6'b000010;
        tick();
        tick();
        check("j ex", 32'(bus.state), 11);
        check("j pcsrc", 32'(bus.pcsrc), 2);
        check("j pcwrite", 32'(bus.pcwrite), 1);
        tick();
        check("j back", 32'(bus.state), 0);
        bus.op = 6'b001000;
        tick();
        tick();
        check("addi ex", 32'(bus.state), 9);
        check("addi alusrcb", 32'(bus.alusrcb), 2);
        tick();
        check("addi wb", 32'(bus.state), 10);
        check("addi regdst", 32'(bus.regdst), 0);
        check("addi regwrite", 32'(bus.regwrite), 1);
        tick();
        check("addi back", 32'(bus.state), 0);

        // Illegal opcode, then FETCH stall
        bus.op = 6'b111111;
        check("ill fetch flag", 32'(bus.illegal_op), 0);
        tick();
        check("ill decode", 32'(bus.state), 1);
        check("ill flag", 32'(bus.illegal_op), 1);
        no_wr("ill");
        bus.mem_ready = 1'b0;
        tick();
        check("ill back", 32'(bus.state), 0);
        check("ill flag off", 32'(bus.illegal_op), 0);
        check("stall irwrite", 32'(bus.irwrite), 0);
        check("stall pcwrite", 32'(bus.pcwrite), 0);
        tick();
        check("stall state", 32'(bus.state), 0);

        // Reset mid-MEMWR
        bus.mem_ready = 1'b1;
        bus.op        = 6'b101011;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("pre rst memwr", 32'(bus.state), 5);
        reset = 1'b1;
        #1;
        check("rst async state", 32'(bus.state), 0);
        check("rst memwrite", 32'(bus.memwrite), 0);
        check("rst stall irwrite", 32'(bus.irwrite), 0);
        tick();
        bus.mem_ready = 1'b1;
        reset         = 1'b0;
        #1;
        check("rel state", 32'(bus.state), 0);
        check("rel irwrite", 32'(bus.irwrite), 1);
        check("rel pcwrite", 32'(bus.pcwrite), 1);
        check("rel memwrite", 32'(bus.memwrite), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control sequencer for the MIPS core. A Moore FSM (plus ready-qualified write strobes) steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared memory port, instruction register, PC, register file and ALU-control selects of the datapath. It supports the R-type, LW, SW, BEQ, ADDI and J opcode set, and handles memory wait states through a ready handshake.

Parameters:
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.
STATE_W, 4, width of the state register and debug port.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high; forces state FETCH.
op  in  6  opcode from the instruction register (IR[31:26]).
mem_ready  in  1  memory completes the current access this cycle.
memreq  out  1  memory access request.
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
memwrite  out  1  memory write enable.
irwrite  out  1  IR load enable.
pcwrite  out  1  unconditional PC write.
branch  out  1  conditional PC write (datapath ANDs with zero).
alusrca  out  1  ALU A select: 0 = PC, 1 = reg A.
alusrcb  out  2  ALU B select: 00 = reg B, 01 = 4, 10 = signimm, 11 = signimm<<2.
aluop  out  2  00 = add, 01 = sub, 10 = use funct.
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
regdst  out  1  write register select: 1 = rd, 0 = rt.
memtoreg  out  1  writeback data select: 1 = memory data, 0 = ALUOut.
regwrite  out  1  register file write enable.
illegal_op  out  1  pulses in DECODE for an unsupported opcode.
state  out  STATE_W  current state (debug).

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are unreachable; they drive all outputs 0 and next state is FETCH.
- Reset: state=FETCH immediately (asynchronous), so outputs take FETCH values (pcwrite/irwrite = mem_ready, all other strobes 0). Reset mid-instruction abandons it; no further write strobe is issued.
- Rdy below = mem_ready (or 1 when MEM_HANDSHAKE=0).
- Any output not listed for a state is 0.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=Rdy, pcwrite=Rdy. Next: DECODE if Rdy, else stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target).
  - Next by op: 100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX.
  - Any other op: illegal_op=1 for this cycle only, next FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=100011, else MEMWR.
- MEMRD: memreq=1, iord=1. Next: MEMWB if Rdy, else stay.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Next: FETCH.
- MEMWR: memreq=1, iord=1, memwrite=1, held through wait states. Next: FETCH if Rdy, else stay.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next: FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next: FETCH.
- JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- Latency with zero wait states, in cycles: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2. Each memory wait state adds 1 cycle.
- op is sampled only in DECODE and MEMADR; the IR holds it stable there because irwrite=0.
- Outputs are combinational from state (plus mem_ready in FETCH) and glitch-free relative to clk.

Test Plan:
- Reset asserted mid-MEMWR with mem_ready=0 -> state=0 immediately, memwrite=0; after release with mem_ready=1, irwrite=pcwrite=1 in the same cycle.
- LW (op=100011), mem_ready=1 always -> state sequence 0,1,2,3,4,0; regwrite=1, memtoreg=1 only in state 4.
- SW (op=101011), mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles with memwrite=1 every cycle; regwrite never asserted; then FETCH.
- R-type (op=000000) then BEQ (op=000100) -> states 0,1,6,7 then 0,1,8. aluop=10 in 6, regdst=1 in 7; branch=1, pcsrc=01, aluop=01 in 8.
- J (op=000010) and ADDI (op=001000) -> J: state 11 with pcsrc=10, pcwrite=1. ADDI: 9 then 10, with alusrcb=10 and regdst=0.
- Illegal op=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, no write strobes. With mem_ready=0 held in FETCH, state stays 0 and irwrite=pcwrite=0.
